hpq_query_arbiter: RTL and testbench
====================================

# hpq_query_arbiter

Front-end scheduler for the HPQ search engine: shares one `hpq` instance between `R` query requesters. It round-robin arbitrates pending queries, latches the winner's query vector, pulses the engine's `start`, and waits for `done`. It then returns `minidx` tagged with the requester ID and a search-latency count. It sits between the host/DMA query ports and the `hpq` top, on the same clock and enable.

## Interface
- `R`, 4: number of requesters (≥2, need not be a power of 2)
- `D`, 32: vector dimension
- `W`, 32: element datawidth
- `IW`, `log2(R)`: requester-ID width (derived; minimum 1)
- `clk` in 1: global clock
- `rst` in 1: reset, asynchronous, active-low
- `ena` in 1: register enable; when low, all state and counters freeze
- `req_valid` in R: requester i has a query pending
- `req_x` in R*W*D: query vectors; slice i is `[i*W*D +: W*D]`
- `req_ready` out R: one-hot accept strobe
- `rsp_valid` out 1: result available
- `rsp_ready` in 1: result consumer accepts
- `rsp_id` out IW: requester that owns the result
- `rsp_minidx` out 32: nearest-vector index
- `rsp_cycles` out 16: engine latency in cycles, saturating
- `hpq_start` out 1: start pulse to the engine
- `hpq_x` out W*D: latched query vector to the engine
- `hpq_done` in 1: engine done
- `hpq_minidx` in 32: engine result
- `busy` out 1: state ≠ IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. No state changes while `ena`=0.
- IDLE
  - Stays in IDLE while no `req_valid` bit is set.
  - Otherwise it grants the first valid index at or after `ptr`, searching upward with wrap R-1→0.
  - In the grant cycle: `req_ready[g]`=1 (combinational, also gated by `ena`), `hpq_x` ← slice g, `id` ← g, `ptr` ← (g+1) mod R, next state ISSUE.
- ISSUE
  - `hpq_start` = (state==ISSUE) & `ena`. It is exactly one enabled cycle wide.
  - `cnt` ← 1. Next state WAIT.
- WAIT
  - Waits for a rising edge of `hpq_done` (`hpq_done`=1 and `done_q`=0). `done_q` is a registered copy of `hpq_done`, updated every enabled cycle, reset 0.
  - A stale high `done` left over from the previous query is therefore ignored until it drops.
  - On the edge: `rsp_minidx` ← `hpq_minidx`, `rsp_cycles` ← `cnt`, next state RESP.
  - Otherwise `cnt` ← min(`cnt`+1, 16'hFFFF).
- RESP
  - `rsp_valid`=1. `rsp_id`, `rsp_minidx` and `rsp_cycles` stay stable.
  - On `rsp_valid`&`rsp_ready`: next state IDLE.
- `req_valid` bits seen while busy are not acknowledged. Requesters must hold `req_valid` and `req_x` until their `req_ready` strobe.
- `rsp_id` and the `rsp_*` data registers hold their last values outside RESP.

## Timing
- Reset values: state IDLE, `ptr` 0, `cnt` 0, `done_q` 0. All outputs are 0: `req_ready`, `rsp_valid`, `rsp_id`, `rsp_minidx`, `rsp_cycles`, `hpq_start`, `hpq_x`, `busy`.
- Accept at cycle t → `hpq_start` at t+1 → WAIT from t+2.
- A done edge at cycle t+1+L gives `rsp_cycles`=L and `rsp_valid` from t+2+L.
- If `rsp_ready` is already high, IDLE is re-entered one cycle after `rsp_valid` rises. A new grant is possible in that IDLE cycle.
- Minimum per-query overhead beyond L: 3 cycles.
- `rsp_cycles` saturates at 65535. The block never times out and waits indefinitely for `done`.
- A done edge during IDLE, ISSUE or RESP is ignored, but `done_q` still tracks it.
- `rst` asserted mid-search: immediate return to IDLE with all outputs cleared. The in-flight result is discarded.
- `ena` low during ISSUE: `hpq_start` is held low and re-issued when `ena` returns.

## Structure
- `log2` comes from `utils.vh`.
- FSM state encodings (2-bit localparams) go in a shared `hpq_defs.vh` so that monitors can decode `state`.
- One sub-module, `rr_arbiter` (parameter R; inputs `req`, `ptr`; outputs one-hot `gnt`, index `gidx`, `any`). It is purely combinational. The FSM owns `ptr`.

## Test plan
- Single query: requester 2 valid, engine raises `done` 5 cycles after `start` with minidx=0x1A3 → `req_ready`=4'b0100 once, one `hpq_start` pulse, `hpq_x` equals slice 2, `rsp_id`=2, `rsp_minidx`=0x1A3, `rsp_cycles`=5.
- Fairness: all 4 valid continuously, `rsp_ready`=1 → grant order 0,1,2,3,0. Then with only 1 and 3 valid from `ptr`=1 → grants 1,3,1.
- Backpressure: `rsp_ready` low for 10 cycles → `rsp_*` stable, no new `req_ready`, `busy`=1. Release → IDLE next cycle.
- Stale done: `hpq_done` held high from the previous query, drops 2 cycles after start, rises again at 7 → `rsp_cycles`=7.
- Saturation and enable: `done` after 70000 cycles → `rsp_cycles`=0xFFFF. `ena`=0 during ISSUE for 3 cycles → `hpq_start` is low in those cycles, then a single pulse.
- Reset mid-WAIT: `rst` low → `busy`=0 and `rsp_valid`=0 immediately, `ptr`=0. After release, a query from requester 0 completes normally.

Source files
------------

// File: rtl/hpq_query_arbiter_pkg.sv
// Shared definitions for the HPQ query arbiter: FSM encodings, widths and
// the requester-ID width helper.
package hpq_query_arbiter_pkg;

    // FSM state encodings, kept as plain 2-bit constants so monitors can
    // decode the state register directly.
    typedef logic [1:0] hpq_state_t;

    localparam hpq_state_t ST_IDLE  = 2'd0;
    localparam hpq_state_t ST_ISSUE = 2'd1;
    localparam hpq_state_t ST_WAIT  = 2'd2;
    localparam hpq_state_t ST_RESP  = 2'd3;

    localparam int          IDX_W   = 32;
    localparam int          CNT_W   = 16;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // Ceiling log2, never less than 1, so a 2-requester system still gets
    // a 1-bit ID and non-power-of-two counts round up.
    function automatic int hpq_log2(input int n);
        int bits;
        bits = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            bits = bits + 1;
        end
        if (bits < 1) begin
            bits = 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/hpq_query_arbiter_rr_arbiter.sv
// Combinational round-robin picker: grants the first requesting index at or
// after the pointer, wrapping from R-1 back to 0. The caller owns the pointer.
module rr_arbiter
    import hpq_query_arbiter_pkg::*;
#(
    parameter int R  = 4,
    parameter int IW = hpq_log2(R)
) (
    input  logic [R-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [R-1:0]  o_gnt,
    output logic [IW-1:0] o_gidx,
    output logic          o_any
);

    int   w_idx;
    logic w_found;

    // Walk the requesters starting at the pointer and keep the first hit.
    always_comb begin
        o_gnt   = '0;
        o_gidx  = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < R; k++) begin
            w_idx = int'(i_ptr) + k;
            if (w_idx >= R) begin
                w_idx = w_idx - R;
            end
            if (!w_found && i_req[w_idx]) begin
                w_found      = 1'b1;
                o_gnt[w_idx] = 1'b1;
                o_gidx       = w_idx[IW-1:0];
            end
        end
        o_any = |i_req;
    end

endmodule

// File: rtl/hpq_query_arbiter.sv
// Shares one HPQ search engine between R query requesters: round-robin
// grant, latch the query, pulse start, wait for a done edge, then hold the
// tagged result until the consumer takes it.
module hpq_query_arbiter
    import hpq_query_arbiter_pkg::*;
#(
    parameter int R  = 4,
    parameter int D  = 32,
    parameter int W  = 32,
    parameter int IW = hpq_log2(R)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_ena,
    input  logic [R-1:0]       i_req_valid,
    input  logic [R*W*D-1:0]   i_req_x,
    output logic [R-1:0]       o_req_ready,
    output logic               o_rsp_valid,
    input  logic               i_rsp_ready,
    output logic [IW-1:0]      o_rsp_id,
    output logic [IDX_W-1:0]   o_rsp_minidx,
    output logic [CNT_W-1:0]   o_rsp_cycles,
    output logic               o_hpq_start,
    output logic [W*D-1:0]     o_hpq_x,
    input  logic               i_hpq_done,
    input  logic [IDX_W-1:0]   i_hpq_minidx,
    output logic               o_busy
);

    localparam int XW = W * D;

    hpq_state_t         r_state;
    logic [IW-1:0]      r_ptr;
    logic [IW-1:0]      r_id;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_cycles;
    logic [IDX_W-1:0]   r_minidx;
    logic               r_done_q;
    logic [XW-1:0]      r_x;

    logic [R-1:0]       w_gnt;
    logic [IW-1:0]      w_gidx;
    logic [IW-1:0]      w_ptr_next;
    logic               w_any;
    logic               w_idle;
    logic               w_done_rise;

    rr_arbiter #(
        .R  (R),
        .IW (IW)
    ) u_arb (
        .i_req  (i_req_valid),
        .i_ptr  (r_ptr),
        .o_gnt  (w_gnt),
        .o_gidx (w_gidx),
        .o_any  (w_any)
    );

    assign w_idle      = (r_state == ST_IDLE);
    assign w_done_rise = i_hpq_done & ~r_done_q;
    assign w_ptr_next  = (int'(w_gidx) == R - 1) ? '0 : w_gidx + 1'b1;

    // The accept strobe is also held off while reset is asserted so every
    // output reads zero during reset, even with requests pending.
    assign o_req_ready  = (w_idle && i_ena && i_rst) ? w_gnt : '0;
    assign o_hpq_start  = (r_state == ST_ISSUE) && i_ena;
    assign o_rsp_valid  = (r_state == ST_RESP);
    assign o_busy       = !w_idle;
    assign o_rsp_id     = r_id;
    assign o_rsp_minidx = r_minidx;
    assign o_rsp_cycles = r_cycles;
    assign o_hpq_x      = r_x;

    // Done-edge history; tracked in every state so a done that is already
    // high when a search starts is not mistaken for its completion.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_done_q <= 1'b0;
        end else if (i_ena) begin
            r_done_q <= i_hpq_done;
        end
    end

    // Query sequencing: grant, one-cycle start, latency count, result hold.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state  <= ST_IDLE;
            r_ptr    <= '0;
            r_id     <= '0;
            r_cnt    <= '0;
            r_cycles <= '0;
            r_minidx <= '0;
            r_x      <= '0;
        end else if (i_ena) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_x     <= i_req_x[int'(w_gidx)*XW +: XW];
                        r_id    <= w_gidx;
                        r_ptr   <= w_ptr_next;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_cnt   <= 16'd1;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_done_rise) begin
                        r_minidx <= i_hpq_minidx;
                        r_cycles <= r_cnt;
                        r_state  <= ST_RESP;
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hpq_query_arbiter.sv
// Self-checking bench for hpq_query_arbiter: a vector table for the
// fairness/backpressure/stale-done/enable cases, randomized queries checked
// against a round-robin reference, plus hand-written saturation and reset
// sequences. The bench plays the role of the engine and the result consumer.
module tb_hpq_query_arbiter;

    localparam int R  = 4;
    localparam int D  = 32;
    localparam int W  = 32;
    localparam int IW = 2;
    localparam int XW = W * D;

    logic               clk;
    logic               i_rst;
    logic               i_ena;
    logic [R-1:0]       i_req_valid;
    logic [R*XW-1:0]    i_req_x;
    logic [R-1:0]       o_req_ready;
    logic               o_rsp_valid;
    logic               i_rsp_ready;
    logic [IW-1:0]      o_rsp_id;
    logic [31:0]        o_rsp_minidx;
    logic [15:0]        o_rsp_cycles;
    logic               o_hpq_start;
    logic [XW-1:0]      o_hpq_x;
    logic               i_hpq_done;
    logic [31:0]        i_hpq_minidx;
    logic               o_busy;

    int errors     = 0;
    int checks     = 0;
    int startCount = 0;
    int modelPtr   = 0;

    typedef struct {
        logic [R-1:0] valid;
        int           expId;
        int           lat;
        logic [31:0]  midx;
        int           bp;
        int           enaOff;
        bit           stale;
        bit           hold;
    } vec_t;

    vec_t vecs[9];

    hpq_query_arbiter #(
        .R (R),
        .D (D),
        .W (W)
    ) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_ena        (i_ena),
        .i_req_valid  (i_req_valid),
        .i_req_x      (i_req_x),
        .o_req_ready  (o_req_ready),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (i_rsp_ready),
        .o_rsp_id     (o_rsp_id),
        .o_rsp_minidx (o_rsp_minidx),
        .o_rsp_cycles (o_rsp_cycles),
        .o_hpq_start  (o_hpq_start),
        .o_hpq_x      (o_hpq_x),
        .i_hpq_done   (i_hpq_done),
        .i_hpq_minidx (i_hpq_minidx),
        .o_busy       (o_busy)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts engine start pulses as the engine would see them at the edge.
    always @(posedge clk) begin
        if (o_hpq_start === 1'b1) begin
            startCount <= startCount + 1;
        end
    end

    // Hard stop in case the design wedges somewhere unforeseen.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference rule: first requester at or after the pointer, wrapping.
    function automatic int pickRR(input logic [R-1:0] v, input int p);
        for (int k = 0; k < R; k++) begin
            int idx;
            idx = (p + k) % R;
            if (v[idx]) begin
                return idx;
            end
        end
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkWide(input string name, input logic [XW-1:0] act, input logic [XW-1:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // One complete query: grant, start, engine latency, response, release.
    task automatic applyStimulus(input logic [R-1:0] valid, input int expId, input int lat,
                                 input logic [31:0] mval, input int bp, input int enaOff,
                                 input bit staleIn, input bit holdDone);
        logic [XW-1:0] slice;
        logic [R-1:0]  oneHot;
        int            waitCnt;
        int            startsBefore;
        int            satCyc;
        bit            granted;

        for (int w = 0; w < R * D; w++) begin
            i_req_x[w*W +: W] = $urandom;
        end
        i_req_valid = valid;
        settle();

        granted = 1'b0;
        waitCnt = 0;
        while (!granted && waitCnt < 10) begin
            if (o_req_ready != '0) begin
                granted = 1'b1;
            end else begin
                tick();
                waitCnt = waitCnt + 1;
            end
        end
        checkOutput("grantSeen", 64'(granted), 64'd1);
        if (!granted) begin
            return;
        end

        oneHot        = '0;
        oneHot[expId] = 1'b1;
        checkOutput("reqReady", 64'(o_req_ready), 64'(oneHot));
        checkOutput("busyInIdle", 64'(o_busy), 64'd0);
        slice        = i_req_x[expId*XW +: XW];
        startsBefore = startCount;

        tick();
        if (enaOff > 0) begin
            i_ena = 1'b0;
            settle();
            for (int i = 0; i < enaOff; i++) begin
                checkOutput("startHeldByEna", 64'(o_hpq_start), 64'd0);
                tick();
            end
            i_ena = 1'b1;
            settle();
        end
        checkOutput("hpqStart", 64'(o_hpq_start), 64'd1);
        checkWide("hpqX", o_hpq_x, slice);
        checkOutput("noReadyWhileBusy", 64'(o_req_ready), 64'd0);
        checkOutput("busyInIssue", 64'(o_busy), 64'd1);

        i_rsp_ready = (bp == 0);
        for (int k = 1; k <= lat; k++) begin
            tick();
            if (staleIn && k == 2) begin
                i_hpq_done = 1'b0;
            end
            if (k == lat) begin
                i_hpq_done   = 1'b1;
                i_hpq_minidx = mval;
            end
            settle();
            if (k == 1) begin
                checkOutput("startSinglePulse", 64'(o_hpq_start), 64'd0);
            end
            if (k == lat) begin
                checkOutput("noEarlyRsp", 64'(o_rsp_valid), 64'd0);
            end
        end

        tick();
        if (!holdDone) begin
            i_hpq_done = 1'b0;
        end
        i_hpq_minidx = $urandom;
        settle();
        satCyc = (lat > 65535) ? 65535 : lat;
        checkOutput("rspValid", 64'(o_rsp_valid), 64'd1);
        checkOutput("rspId", 64'(o_rsp_id), 64'(expId));
        checkOutput("rspMinidx", 64'(o_rsp_minidx), 64'(mval));
        checkOutput("rspCycles", 64'(o_rsp_cycles), 64'(satCyc));
        checkOutput("startCount", 64'(startCount - startsBefore), 64'd1);

        for (int i = 0; i < bp; i++) begin
            tick();
            checkOutput("bpValid", 64'(o_rsp_valid), 64'd1);
            checkOutput("bpMinidx", 64'(o_rsp_minidx), 64'(mval));
            checkOutput("bpId", 64'(o_rsp_id), 64'(expId));
            checkOutput("bpNoReady", 64'(o_req_ready), 64'd0);
            checkOutput("bpBusy", 64'(o_busy), 64'd1);
        end
        i_rsp_ready = 1'b1;

        tick();
        checkOutput("idleAfterRsp", 64'(o_busy), 64'd0);
        checkOutput("rspDropped", 64'(o_rsp_valid), 64'd0);
        checkOutput("rspHeldMinidx", 64'(o_rsp_minidx), 64'(mval));
        checkOutput("rspHeldCycles", 64'(o_rsp_cycles), 64'(satCyc));
        modelPtr = (expId + 1) % R;
    endtask

    // Main test sequence.
    initial begin
        int           expId;
        logic [R-1:0] v;

        i_rst        = 1'b0;
        i_ena        = 1'b1;
        i_req_valid  = 4'b1111;
        i_req_x      = '0;
        i_rsp_ready  = 1'b0;
        i_hpq_done   = 1'b0;
        i_hpq_minidx = '0;
        for (int w = 0; w < R * D; w++) begin
            i_req_x[w*W +: W] = $urandom;
        end

        vecs[0] = '{4'b1000, 3, 4, 32'h11, 0,  0, 1'b0, 1'b0};
        vecs[1] = '{4'b1111, 0, 3, 32'h22, 0,  0, 1'b0, 1'b0};
        vecs[2] = '{4'b1111, 1, 6, 32'h33, 10, 0, 1'b0, 1'b0};
        vecs[3] = '{4'b1111, 2, 2, 32'h44, 0,  3, 1'b0, 1'b0};
        vecs[4] = '{4'b1111, 3, 5, 32'h55, 0,  0, 1'b0, 1'b1};
        vecs[5] = '{4'b1111, 0, 7, 32'h66, 0,  0, 1'b1, 1'b0};
        vecs[6] = '{4'b1010, 1, 1, 32'h77, 0,  0, 1'b0, 1'b0};
        vecs[7] = '{4'b1010, 3, 9, 32'h88, 1,  0, 1'b0, 1'b0};
        vecs[8] = '{4'b1010, 1, 3, 32'h99, 0,  0, 1'b0, 1'b0};

        repeat (2) tick();
        checkOutput("rstReqReady", 64'(o_req_ready), 64'd0);
        checkOutput("rstRspValid", 64'(o_rsp_valid), 64'd0);
        checkOutput("rstRspId", 64'(o_rsp_id), 64'd0);
        checkOutput("rstRspMinidx", 64'(o_rsp_minidx), 64'd0);
        checkOutput("rstRspCycles", 64'(o_rsp_cycles), 64'd0);
        checkOutput("rstStart", 64'(o_hpq_start), 64'd0);
        checkOutput("rstBusy", 64'(o_busy), 64'd0);
        checkWide("rstHpqX", o_hpq_x, '0);

        i_req_valid = '0;
        i_rst       = 1'b1;
        tick();

        $display("[TB] single query from requester 2");
        applyStimulus(4'b0100, 2, 5, 32'h1A3, 0, 0, 1'b0, 1'b0);

        $display("[TB] vector table: fairness, backpressure, enable, stale done");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].expId, vecs[i].lat, vecs[i].midx,
                          vecs[i].bp, vecs[i].enaOff, vecs[i].stale, vecs[i].hold);
        end

        $display("[TB] randomized queries");
        for (int i = 0; i < 24; i++) begin
            v     = 4'($urandom_range(1, 15));
            expId = pickRR(v, modelPtr);
            applyStimulus(v, expId, int'($urandom_range(1, 12)), $urandom,
                          int'($urandom_range(0, 3)), 0, 1'b0, 1'b0);
        end

        $display("[TB] latency counter saturation");
        expId = pickRR(4'b0010, modelPtr);
        applyStimulus(4'b0010, expId, 66000, 32'hCAFE, 0, 0, 1'b0, 1'b0);

        $display("[TB] reset during search");
        i_req_valid = 4'b0100;
        i_rsp_ready = 1'b0;
        settle();
        checkOutput("rstSeqGrant", 64'(o_req_ready), 64'(4'b0100));
        tick();
        checkOutput("rstSeqStart", 64'(o_hpq_start), 64'd1);
        i_req_valid = '0;
        repeat (3) tick();
        checkOutput("rstSeqBusy", 64'(o_busy), 64'd1);
        i_rst = 1'b0;
        #1;
        checkOutput("midRstBusy", 64'(o_busy), 64'd0);
        checkOutput("midRstRspValid", 64'(o_rsp_valid), 64'd0);
        checkOutput("midRstCycles", 64'(o_rsp_cycles), 64'd0);
        checkOutput("midRstMinidx", 64'(o_rsp_minidx), 64'd0);
        checkOutput("midRstId", 64'(o_rsp_id), 64'd0);
        checkWide("midRstHpqX", o_hpq_x, '0);
        tick();
        i_rst = 1'b1;
        tick();
        modelPtr = 0;
        applyStimulus(4'b1111, 0, 4, 32'hBEEF, 0, 0, 1'b0, 1'b0);

        i_req_valid = '0;
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
